// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the unified-memory data-port arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CPU       = 2'd1,
      DMA_BURST = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   localparam int STAT_W = 16;
   localparam int CNT_W  = 8;

   function automatic logic is_read(input logic gnt, input logic we);
      return gnt & ~we;
   endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // count register: reset, clear, saturating increment
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= {WIDTH{1'b0}};
      end else if (clr) begin
         cnt <= {WIDTH{1'b0}};
      end else if (inc && (cnt != LIMIT)) begin
         cnt <= cnt + ONE;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the memory data port between the CPU dmem stage and the DMA engine.
// Define DMEM_ARB_STATS_EN to build the stall/grant statistics counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DBITS     = 16,
   parameter int ABITS     = 12,
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [DBITS-1:0]  cpu_addr,
   input  logic [DBITS-1:0]  cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic              dma_lock,
   input  logic [DBITS-1:0]  dma_addr,
   input  logic [DBITS-1:0]  dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DBITS-1:0]  rdata,
   output logic [ABITS-1:0]  mem_addr,
   output logic [DBITS-1:0]  mem_din,
   output logic              mem_we,
   input  logic [DBITS-1:0]  mem_dout,
   output logic [STAT_W-1:0] stat_cpu_stall,
   output logic [STAT_W-1:0] stat_dma_gnt,
   input  logic              stat_clr
);

   arb_state_t       state;
   owner_t           rd_own;
   logic             rd_pend;
   logic             cpu_gnt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] burst_cnt;
   logic             wait_full;
   logic             burst_full;
   logic             wait_inc;
   logic             wait_clr;
   logic             burst_clr;

   assign wait_full  = (wait_cnt == MAX_WAIT[CNT_W-1:0]);
   assign burst_full = (burst_cnt == BURST_MAX[CNT_W-1:0]);
   assign wait_inc   = dma_req & ~dma_gnt;
   assign wait_clr   = ~dma_req | dma_gnt;
   assign burst_clr  = ~(dma_gnt & dma_lock);

   // grant decision; nobody owns the port while reset is asserted
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (rst) begin
         cpu_gnt = 1'b0;
         dma_gnt = 1'b0;
      end else begin
         case (state)
            DMA_BURST: begin
               // a full burst yields one cycle to a waiting CPU even if locked
               if (cpu_req && burst_full) begin
                  cpu_gnt = 1'b1;
               end else if (dma_req) begin
                  dma_gnt = 1'b1;
               end else if (cpu_req) begin
                  cpu_gnt = 1'b1;
               end else begin
                  cpu_gnt = 1'b0;
               end
            end
            IDLE, CPU: begin
               if (dma_req && (!cpu_req || wait_full)) begin
                  dma_gnt = 1'b1;
               end else if (cpu_req) begin
                  cpu_gnt = 1'b1;
               end else begin
                  cpu_gnt = 1'b0;
               end
            end
            default: begin
               cpu_gnt = 1'b0;
               dma_gnt = 1'b0;
            end
         endcase
      end
   end

   // memory port mux driven by the current owner
   always_comb begin
      cpu_stall = cpu_req & ~cpu_gnt & ~rst;
      mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
      if (dma_gnt) begin
         mem_addr = dma_addr[ABITS:1];
         mem_din  = dma_wdata;
      end else if (cpu_gnt) begin
         mem_addr = cpu_addr[ABITS:1];
         mem_din  = cpu_wdata;
      end else begin
         mem_addr = {ABITS{1'b0}};
         mem_din  = {DBITS{1'b0}};
      end
   end

   // ownership state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (dma_gnt && dma_lock) begin
         state <= DMA_BURST;
      end else if (cpu_gnt) begin
         state <= CPU;
      end else begin
         state <= IDLE;
      end
   end

   // read return pipeline: owner tag travels with the pending read
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend    <= 1'b0;
         rd_own     <= OWN_CPU;
         cpu_rvalid <= 1'b0;
         dma_rvalid <= 1'b0;
         rdata      <= {DBITS{1'b0}};
      end else begin
         rd_pend    <= is_read(cpu_gnt, cpu_we) | is_read(dma_gnt, dma_we);
         rd_own     <= dma_gnt ? OWN_DMA : OWN_CPU;
         cpu_rvalid <= rd_pend & (rd_own == OWN_CPU);
         dma_rvalid <= rd_pend & (rd_own == OWN_DMA);
         if (rd_pend) begin
            rdata <= mem_dout;
         end else begin
            rdata <= rdata;
         end
      end
   end

   arb_sat_counter #(.WIDTH(CNT_W), .LIMIT(MAX_WAIT[CNT_W-1:0])) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .clr (wait_clr),
      .inc (wait_inc),
      .cnt (wait_cnt)
   );

   arb_sat_counter #(.WIDTH(CNT_W), .LIMIT(BURST_MAX[CNT_W-1:0])) u_burst_cnt (
      .clk (clk),
      .rst (rst),
      .clr (burst_clr),
      .inc (dma_gnt),
      .cnt (burst_cnt)
   );

`ifdef DMEM_ARB_STATS_EN
   arb_sat_counter #(.WIDTH(STAT_W)) u_stat_stall (
      .clk (clk),
      .rst (rst),
      .clr (stat_clr),
      .inc (cpu_stall),
      .cnt (stat_cpu_stall)
   );

   arb_sat_counter #(.WIDTH(STAT_W)) u_stat_gnt (
      .clk (clk),
      .rst (rst),
      .clr (stat_clr),
      .inc (dma_gnt),
      .cnt (stat_dma_gnt)
   );
`else
   logic unused_stat;
   assign stat_cpu_stall = {STAT_W{1'b0}};
   assign stat_dma_gnt   = {STAT_W{1'b0}};
   assign unused_stat    = stat_clr;
`endif

   // byte-lane bit and address bits above the memory are not decoded here
   logic unused_addr;
   assign unused_addr = ^{cpu_addr[DBITS-1:ABITS+1], cpu_addr[0],
                          dma_addr[DBITS-1:ABITS+1], dma_addr[0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic
// against a rule-level reference model.
module tb_dmem_arbiter;

   localparam int MAX_WAIT  = 8;
   localparam int BURST_MAX = 16;

`ifdef DMEM_ARB_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock, stat_clr;
   logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
   logic [15:0] rdata, mem_din, mem_dout;
   logic [11:0] mem_addr;
   logic [15:0] stat_cpu_stall, stat_dma_gnt;

   dmem_arbiter #(.DBITS(16), .ABITS(12), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout), .stat_cpu_stall(stat_cpu_stall), .stat_dma_gnt(stat_dma_gnt),
      .stat_clr(stat_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(input logic [11:0] a);
      if (a == 12'h102) return 16'hBEEF;
      return {a, 4'h0} ^ 16'h5A3C;
   endfunction

   // memory array with one-cycle synchronous read
   logic [15:0] mem [4096];
   bit          mem_vld [4096];
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr]     <= mem_din;
         mem_vld[mem_addr] <= 1'b1;
      end
      mem_dout <= mem_vld[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model state
   typedef struct { int due; bit dma; logic [15:0] data; } rd_t;
   rd_t         rq[$];
   logic [15:0] mdl_mem [4096];
   int          denied = 0;
   int          beats = 0;
   bit          locked = 1'b0;
   int          n_stall = 0;
   int          n_dgnt = 0;
   bit          armed = 1'b0;
   bit          after_rst = 1'b0;

   task automatic sample();
      bit gc, gd, ec, ed;
      logic [15:0] edata;
      @(negedge clk);
      gc = 1'b0; gd = 1'b0;
      if (!rst) begin
         if (locked) begin
            if (cpu_req && beats >= BURST_MAX) gc = 1'b1;
            else if (dma_req) gd = 1'b1;
            else if (cpu_req) gc = 1'b1;
         end else begin
            if (dma_req && (!cpu_req || denied >= MAX_WAIT)) gd = 1'b1;
            else if (cpu_req) gc = 1'b1;
         end
      end
      ec = 1'b0; ed = 1'b0; edata = 16'h0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         ec = !rq[0].dma;
         ed = rq[0].dma;
         edata = rq[0].data;
         void'(rq.pop_front());
      end
      if (armed) begin
         chk("cpu_stall", cpu_stall, !rst && cpu_req && !gc);
         chk("dma_gnt", dma_gnt, gd);
         chk("mem_we", mem_we, (gc && cpu_we) || (gd && dma_we));
         if (gc) chk("mem_addr_cpu", mem_addr, cpu_addr[12:1]);
         if (gd) chk("mem_addr_dma", mem_addr, dma_addr[12:1]);
         if (gc && cpu_we) chk("mem_din_cpu", mem_din, cpu_wdata);
         if (gd && dma_we) chk("mem_din_dma", mem_din, dma_wdata);
         chk("cpu_rvalid", cpu_rvalid, ec);
         chk("dma_rvalid", dma_rvalid, ed);
         if (ec || ed) chk("rdata", rdata, edata);
         if (after_rst) chk("rdata_after_rst", rdata, 16'h0);
         chk("stat_cpu_stall", stat_cpu_stall, STATS_ON ? n_stall : 0);
         chk("stat_dma_gnt", stat_dma_gnt, STATS_ON ? n_dgnt : 0);
      end
      if (rst) begin
         denied = 0; beats = 0; locked = 1'b0; rq.delete();
         n_stall = 0; n_dgnt = 0; after_rst = 1'b1; armed = 1'b1;
      end else begin
         after_rst = 1'b0;
         if (gc) begin
            if (cpu_we) mdl_mem[cpu_addr[12:1]] = cpu_wdata;
            else rq.push_back('{due: cyc + 2, dma: 1'b0, data: mdl_mem[cpu_addr[12:1]]});
         end
         if (gd) begin
            if (dma_we) mdl_mem[dma_addr[12:1]] = dma_wdata;
            else rq.push_back('{due: cyc + 2, dma: 1'b1, data: mdl_mem[dma_addr[12:1]]});
         end
         if (gd || !dma_req) denied = 0;
         else if (denied < MAX_WAIT) denied++;
         if (gd && dma_lock) begin
            beats = locked ? ((beats < BURST_MAX) ? beats + 1 : beats) : 1;
            locked = 1'b1;
         end else begin
            beats = 0;
            locked = 1'b0;
         end
         if (stat_clr) begin
            n_stall = 0; n_dgnt = 0;
         end else begin
            if (cpu_req && !gc && n_stall < 65535) n_stall++;
            if (gd && n_dgnt < 65535) n_dgnt++;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
      stat_clr = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      for (int i = 0; i < n; i++) begin
         sample(); advance();
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mdl_mem[i] = init_word(12'(i));
      set_idle();
      rst = 1'b1;
      sample(); advance();
      sample(); advance();
      rst = 1'b0;
      sample();
      chk("reset_stall", cpu_stall, 1'b0);
      chk("reset_gnt", dma_gnt, 1'b0);
      chk("reset_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
      chk("reset_rdata", rdata, 16'h0);
      advance();

      // continuous contention: DMA forced in every ninth cycle
      cpu_req = 1'b1; cpu_addr = 16'h0040; dma_req = 1'b1; dma_addr = 16'h0080;
      for (int k = 0; k < 27; k++) begin
         sample();
         chk("contend_dma_gnt", dma_gnt, (k % 9) == 8);
         chk("contend_cpu_stall", cpu_stall, (k % 9) == 8);
         advance();
      end
      idle_cycles(3);

      // CPU read of word 0x102
      cpu_req = 1'b1; cpu_addr = 16'h0204;
      sample();
      chk("cpu_read_addr", mem_addr, 12'h102);
      advance();
      set_idle();
      sample(); advance();
      sample();
      chk("cpu_read_rvalid", cpu_rvalid, 1'b1);
      chk("cpu_read_rdata", rdata, 16'hBEEF);
      advance();
      idle_cycles(2);

      // locked DMA burst, CPU waits from beat 3 and is served once burst is full
      for (int t = 0; t < 21; t++) begin
         dma_req = 1'b1; dma_lock = (t != 20); dma_addr = 16'(16'h0400 + 2 * t);
         cpu_req = (t >= 3 && t <= 16); cpu_addr = 16'h0010;
         sample();
         chk("burst_dma_gnt", dma_gnt, t != 16);
         chk("burst_cpu_stall", cpu_stall, t >= 3 && t < 16);
         advance();
      end
      idle_cycles(3);

      // CPU write wins over a DMA read request
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'h1234;
      dma_req = 1'b1; dma_addr = 16'h0500;
      sample();
      chk("cpu_wr_we", mem_we, 1'b1);
      chk("cpu_wr_addr", mem_addr, 12'h180);
      chk("cpu_wr_din", mem_din, 16'h1234);
      chk("cpu_wr_dma_gnt", dma_gnt, 1'b0);
      advance();
      idle_cycles(3);

      // reset right after a DMA read grant squashes its rvalid
      dma_req = 1'b1; dma_addr = 16'h0020;
      sample(); advance();
      set_idle();
      rst = 1'b1;
      sample(); advance();
      rst = 1'b0;
      sample();
      chk("rst_squash_dma_rvalid", dma_rvalid, 1'b0);
      chk("rst_squash_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("rst_squash_rdata", rdata, 16'h0);
      chk("rst_squash_we", mem_we, 1'b0);
      advance();

      // five CPU stall cycles behind a locked burst, then statistics clear
      for (int t = 0; t < 7; t++) begin
         dma_req = 1'b1; dma_lock = (t != 6); dma_addr = 16'(16'h0600 + 2 * t);
         cpu_req = (t >= 1 && t <= 5);
         sample(); advance();
      end
      set_idle();
      stat_clr = 1'b1;
      sample();
      chk("stat_stall_5", stat_cpu_stall, STATS_ON ? 16'd5 : 16'd0);
      chk("stat_gnt_7", stat_dma_gnt, STATS_ON ? 16'd7 : 16'd0);
      advance();
      stat_clr = 1'b0;
      sample();
      chk("stat_stall_clr", stat_cpu_stall, 16'd0);
      chk("stat_gnt_clr", stat_dma_gnt, 16'd0);
      advance();

      // random traffic, second half with heavy DMA to exercise long bursts
      for (int n = 0; n < 800; n++) begin
         cpu_req   = ($urandom_range(0, 3) != 0);
         cpu_we    = $urandom_range(0, 1) == 1;
         cpu_addr  = 16'($urandom_range(0, 127));
         cpu_wdata = 16'($urandom);
         dma_req   = (n < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) != 0);
         dma_we    = $urandom_range(0, 1) == 1;
         dma_lock  = ($urandom_range(0, 4) != 0);
         dma_addr  = 16'($urandom_range(0, 127));
         dma_wdata = 16'($urandom);
         stat_clr  = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 150) == 0);
         sample(); advance();
      end
      rst = 1'b0;
      idle_cycles(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
